// File: rtl/uart_rx_deser_frame_if.sv
// Handshake bundle between the bit sampler / RX consumer and the UART
// receive frame assembler. The slave side is the assembler itself.
interface uart_rx_deser_frame_if #(
    parameter int DATA_WIDTH = 8
);
    // Sampler-side inputs to the assembler
    logic                  frame_start;
    logic                  bit_valid;
    logic                  sampled_bit;
    logic                  par_en;
    logic                  par_odd;
    logic                  msb_first;
    // Consumer-side acknowledge
    logic                  data_ack;
    // Assembler outputs
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  overrun;
    logic                  busy;

    modport master (
        output frame_start, bit_valid, sampled_bit, par_en, par_odd, msb_first, data_ack,
        input  P_DATA, data_valid, par_err, stp_err, overrun, busy
    );

    modport slave (
        input  frame_start, bit_valid, sampled_bit, par_en, par_odd, msb_first, data_ack,
        output P_DATA, data_valid, par_err, stp_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_deser_frame.sv
// UART receive frame assembler: collects sampled bits after a start pulse,
// tracks data / optional parity / stop positions, and hands the checked word
// to a valid/ack holding register with parity, stop and overrun reporting.
module uart_rx_deser_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input logic                  CLK,
    input logic                  RST,
    uart_rx_deser_frame_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 16) begin : g_bad_width
        $error("uart_rx_deser_frame: DATA_WIDTH must be within 5..16");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_rx_deser_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Control strobes decoded from the FSM
    logic accept;
    logic shift_en;
    logic par_smp;
    logic stop_smp;
    logic commit;
    logic cnt_clr;
    logic cnt_inc;

    // Frame assembly stage
    logic [CNT_W-1:0]      cnt_p0;
    logic [DATA_WIDTH-1:0] shreg_p0;
    logic                  acc_p0;
    logic                  perr_p0;
    logic                  serr_p0;
    logic                  cfg_par_en_p0;
    logic                  cfg_msb_p0;

    // Output holding stage
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  perr_p1;
    logic                  serr_p1;
    logic                  vld_p1;
    logic                  ovr_p1;

    logic slot_free;
    logic serr_final;

    // Places a new bit into the shift register according to the latched order:
    // LSB-first enters at the top and moves down, MSB-first enters at the bottom.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  b,
        input logic                  msb
    );
        if (msb) begin
            return {cur[DATA_WIDTH-2:0], b};
        end
        return {b, cur[DATA_WIDTH-1:1]};
    endfunction

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; nothing moves without a bit strobe
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift_en  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        commit    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.frame_start) begin
                    accept    = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bus.bit_valid) begin
                    shift_en = 1'b1;
                    if (cnt_p0 == LAST_DATA) begin
                        cnt_clr   = 1'b1;
                        state_nxt = cfg_par_en_p0 ? PARITY : STOP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bus.bit_valid) begin
                    par_smp   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bus.bit_valid) begin
                    stop_smp = 1'b1;
                    if (cnt_p0 == LAST_STOP) begin
                        commit    = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame assembly: position counter, shift register, parity and stop tracking
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_p0        <= '0;
            shreg_p0      <= '0;
            acc_p0        <= 1'b0;
            perr_p0       <= 1'b0;
            serr_p0       <= 1'b0;
            cfg_par_en_p0 <= 1'b0;
            cfg_msb_p0    <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt_p0 <= '0;
            end else if (cnt_inc) begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
            if (accept) begin
                // Seeding with par_odd makes a zero final result mean "good" for both types
                shreg_p0      <= '0;
                acc_p0        <= bus.par_odd;
                perr_p0       <= 1'b0;
                serr_p0       <= 1'b0;
                cfg_par_en_p0 <= bus.par_en;
                cfg_msb_p0    <= bus.msb_first;
            end
            if (shift_en) begin
                shreg_p0 <= shift_in(shreg_p0, bus.sampled_bit, cfg_msb_p0);
                acc_p0   <= acc_p0 ^ bus.sampled_bit;
            end
            if (par_smp) begin
                perr_p0 <= acc_p0 ^ bus.sampled_bit;
            end
            if (stop_smp) begin
                serr_p0 <= serr_p0 | ~bus.sampled_bit;
            end
        end
    end

    // The final stop bit is folded in combinationally so the word commits on its strobe
    assign serr_final = serr_p0 | ~bus.sampled_bit;
    assign slot_free  = ~vld_p1 | bus.data_ack;

    // Output holding register with valid/ack handshake and overrun pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_p1 <= '0;
            perr_p1 <= 1'b0;
            serr_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            ovr_p1  <= 1'b0;
        end else begin
            ovr_p1 <= commit & ~slot_free;
            if (commit && slot_free) begin
                data_p1 <= shreg_p0;
                perr_p1 <= perr_p0;
                serr_p1 <= serr_final;
                vld_p1  <= 1'b1;
            end else if (bus.data_ack) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.P_DATA     = data_p1;
    assign bus.data_valid = vld_p1;
    assign bus.par_err    = perr_p1;
    assign bus.stp_err    = serr_p1;
    assign bus.overrun    = ovr_p1;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_deser_frame.sv
// Bench for the UART receive frame assembler. Three instances cover
// 8-bit/1-stop, 8-bit/2-stop and 5-bit/1-stop; one is selected at a time.
module tb_uart_rx_deser_frame;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int   sel;
    logic frame_start, bit_valid, sampled_bit, par_en, par_odd, msb_first, data_ack;

    uart_rx_deser_frame_if #(.DATA_WIDTH(8)) if_a ();
    uart_rx_deser_frame_if #(.DATA_WIDTH(8)) if_b ();
    uart_rx_deser_frame_if #(.DATA_WIDTH(5)) if_c ();

    assign if_a.frame_start = frame_start && (sel == 0);
    assign if_a.bit_valid   = bit_valid && (sel == 0);
    assign if_a.data_ack    = data_ack && (sel == 0);
    assign if_a.sampled_bit = sampled_bit;
    assign if_a.par_en      = par_en;
    assign if_a.par_odd     = par_odd;
    assign if_a.msb_first   = msb_first;

    assign if_b.frame_start = frame_start && (sel == 1);
    assign if_b.bit_valid   = bit_valid && (sel == 1);
    assign if_b.data_ack    = data_ack && (sel == 1);
    assign if_b.sampled_bit = sampled_bit;
    assign if_b.par_en      = par_en;
    assign if_b.par_odd     = par_odd;
    assign if_b.msb_first   = msb_first;

    assign if_c.frame_start = frame_start && (sel == 2);
    assign if_c.bit_valid   = bit_valid && (sel == 2);
    assign if_c.data_ack    = data_ack && (sel == 2);
    assign if_c.sampled_bit = sampled_bit;
    assign if_c.par_en      = par_en;
    assign if_c.par_odd     = par_odd;
    assign if_c.msb_first   = msb_first;

    uart_rx_deser_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (.CLK(CLK), .RST(RST), .bus(if_a));
    uart_rx_deser_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (.CLK(CLK), .RST(RST), .bus(if_b));
    uart_rx_deser_frame #(.DATA_WIDTH(5), .STOP_BITS(1)) dut_c (.CLK(CLK), .RST(RST), .bus(if_c));

    // Outputs of the currently selected instance
    logic [15:0] o_data;
    logic        o_vld, o_pe, o_se, o_ovr, o_busy;
    always_comb begin
        o_data = '0;
        o_vld  = 1'b0;
        o_pe   = 1'b0;
        o_se   = 1'b0;
        o_ovr  = 1'b0;
        o_busy = 1'b0;
        case (sel)
            0: begin
                o_data = {8'h00, if_a.P_DATA};
                o_vld = if_a.data_valid; o_pe = if_a.par_err; o_se = if_a.stp_err;
                o_ovr = if_a.overrun; o_busy = if_a.busy;
            end
            1: begin
                o_data = {8'h00, if_b.P_DATA};
                o_vld = if_b.data_valid; o_pe = if_b.par_err; o_se = if_b.stp_err;
                o_ovr = if_b.overrun; o_busy = if_b.busy;
            end
            default: begin
                o_data = {11'h000, if_c.P_DATA};
                o_vld = if_c.data_valid; o_pe = if_c.par_err; o_se = if_c.stp_err;
                o_ovr = if_c.overrun; o_busy = if_c.busy;
            end
        endcase
    end

    int compared   = 0;
    int mismatched = 0;
    bit rnd        = 1'b0;

    // Reference model of each instance's holding slot
    bit          ev  [3];
    logic [15:0] ed  [3];
    bit          epe [3];
    bit          ese [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h (dut %0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int wid(input int s);
        return (s == 2) ? 5 : 8;
    endfunction

    function automatic int nstop(input int s);
        return (s == 1) ? 2 : 1;
    endfunction

    // Word value implied by the bit order: transmission index i carries weight 2^i
    // for LSB-first and 2^(w-1-i) for MSB-first.
    function automatic logic [15:0] model_word(input logic [15:0] seq, input int w, input bit msb);
        int acc = 0;
        for (int i = 0; i < w; i++) begin
            if (seq[i]) acc += 1 << (msb ? (w - 1 - i) : i);
        end
        return 16'(acc);
    endfunction

    task automatic check_slot(input string tag);
        check({tag, "_vld"}, 32'(o_vld), 32'(ev[sel]));
        check({tag, "_data"}, 32'(o_data), 32'(ed[sel]));
        if (ev[sel]) begin
            check({tag, "_par_err"}, 32'(o_pe), 32'(epe[sel]));
            check({tag, "_stp_err"}, 32'(o_se), 32'(ese[sel]));
        end
    endtask

    // Idle cycles with junk on the config lines and stray start pulses
    task automatic gap();
        int n;
        if (!rnd) return;
        n = $urandom_range(0, 2);
        repeat (n) begin
            frame_start = ($urandom_range(0, 3) == 0);
            par_en      = 1'($urandom);
            par_odd     = 1'($urandom);
            msb_first   = 1'($urandom);
            sampled_bit = 1'($urandom);
            tick();
        end
        frame_start = 1'b0;
    endtask

    task automatic strobe(input logic b);
        gap();
        sampled_bit = b;
        bit_valid   = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic start(input int s, input bit pe, input bit po, input bit msb);
        sel         = s;
        par_en      = pe;
        par_odd     = po;
        msb_first   = msb;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("busy_start", 32'(o_busy), 32'd1);
    endtask

    task automatic send_frame(input int s, input logic [15:0] seq, input bit pe, input bit po,
                              input bit msb, input bit pbit, input logic [1:0] stp,
                              input bit ack_last);
        int w, ns, ones;
        bit xpe, xse, xovr, free;
        w  = wid(s);
        ns = nstop(s);
        start(s, pe, po, msb);
        for (int i = 0; i < w; i++) strobe(seq[i]);
        if (pe) strobe(pbit);
        for (int k = 0; k < ns; k++) begin
            gap();
            sampled_bit = stp[k];
            bit_valid   = 1'b1;
            if (k == ns - 1) data_ack = ack_last;
            tick();
            bit_valid = 1'b0;
            data_ack  = 1'b0;
        end
        ones = 0;
        for (int i = 0; i < w; i++) ones += int'(seq[i]);
        xpe = pe && (((ones + int'(pbit) + int'(po)) % 2) == 1);
        xse = 1'b0;
        for (int k = 0; k < ns; k++) if (!stp[k]) xse = 1'b1;
        free = !ev[s] || ack_last;
        if (free) begin
            ev[s]  = 1'b1;
            ed[s]  = model_word(seq, w, msb);
            epe[s] = xpe;
            ese[s] = xse;
            xovr   = 1'b0;
        end else begin
            xovr = 1'b1;
        end
        check_slot("commit");
        check("overrun", 32'(o_ovr), 32'(xovr));
        check("busy_end", 32'(o_busy), 32'd0);
        tick();
        check("overrun_pulse", 32'(o_ovr), 32'd0);
    endtask

    task automatic do_ack(input int s);
        sel      = s;
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        ev[s]    = 1'b0;
        check("ack_vld", 32'(o_vld), 32'd0);
        check("ack_hold", 32'(o_data), 32'(ed[s]));
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check({tag, "_data"}, 32'(o_data), 32'd0);
            check({tag, "_vld"}, 32'(o_vld), 32'd0);
            check({tag, "_pe"}, 32'(o_pe), 32'd0);
            check({tag, "_se"}, 32'(o_se), 32'd0);
            check({tag, "_ovr"}, 32'(o_ovr), 32'd0);
            check({tag, "_busy"}, 32'(o_busy), 32'd0);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int s = 0; s < 3; s++) begin
            ev[s] = 1'b0; ed[s] = '0; epe[s] = 1'b0; ese[s] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; frame_start = 0; bit_valid = 0; sampled_bit = 0;
        par_en = 0; par_odd = 0; msb_first = 0; data_ack = 0;
        RST = 1'b1;
        repeat (2) tick();
        do_reset();
        check_all_zero("reset");

        // Basic LSB-first frame
        send_frame(0, 16'h00A5, 0, 0, 0, 0, 2'b11, 0);
        check("t1_data", 32'(o_data), 32'h0A5);
        do_ack(0);
        do_ack(0);

        // Bit order
        send_frame(0, 16'h00A5, 0, 0, 1, 0, 2'b11, 0);
        check("t2_msb_a5", 32'(o_data), 32'h0A5);
        do_ack(0);
        send_frame(0, 16'h0003, 0, 0, 1, 0, 2'b11, 0);
        check("t2_msb_c0", 32'(o_data), 32'h0C0);
        do_ack(0);
        send_frame(0, 16'h0003, 0, 0, 0, 0, 2'b11, 0);
        check("t2_lsb_03", 32'(o_data), 32'h003);
        do_ack(0);

        // Parity
        send_frame(0, 16'h0007, 1, 0, 0, 0, 2'b11, 0);
        check("t3_even_bad", 32'(o_pe), 32'd1);
        do_ack(0);
        send_frame(0, 16'h0007, 1, 0, 0, 1, 2'b11, 0);
        check("t3_even_good", 32'(o_pe), 32'd0);
        do_ack(0);
        send_frame(0, 16'h0007, 1, 1, 0, 0, 2'b11, 0);
        check("t3_odd_good", 32'(o_pe), 32'd0);
        do_ack(0);

        // Two stop bits, second one low
        send_frame(1, 16'h003C, 0, 0, 0, 0, 2'b01, 0);
        check("t4_data", 32'(o_data), 32'h03C);
        check("t4_stp_err", 32'(o_se), 32'd1);
        do_ack(1);

        // Overrun, then ack coinciding with commit
        send_frame(0, 16'h0011, 0, 0, 0, 0, 2'b11, 0);
        send_frame(0, 16'h0022, 0, 0, 0, 0, 2'b11, 0);
        check("t5_kept", 32'(o_data), 32'h011);
        send_frame(0, 16'h0033, 0, 0, 0, 0, 2'b11, 1);
        check("t5_new", 32'(o_data), 32'h033);
        check("t5_vld", 32'(o_vld), 32'd1);
        do_ack(0);

        // Reset mid-frame with a word held
        send_frame(0, 16'h0044, 0, 0, 0, 0, 2'b11, 0);
        start(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_busy", 32'(o_busy), 32'd1);
        do_reset();
        check_all_zero("t6_reset");
        send_frame(0, 16'h005A, 0, 0, 0, 0, 2'b11, 0);
        check("t6_fresh", 32'(o_data), 32'h05A);
        do_ack(0);
        send_frame(2, 16'h0015, 0, 0, 0, 0, 2'b11, 0);
        check("t6_w5", 32'(o_data), 32'h015);
        do_ack(2);

        // Randomized traffic against the model
        rnd = 1'b1;
        repeat (300) begin
            int          s;
            logic [15:0] seq;
            logic [1:0]  stp;
            s   = $urandom_range(0, 2);
            seq = 16'($urandom);
            stp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 2) == 0) do_ack(s);
            send_frame(s, seq, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       stp, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_rx_deser_frame.md
Name: uart_rx_deser_frame

Overview:
- Parametrised serial-to-parallel frame assembler for the UART receive path.
- Sits between the bit sampler and the RX output interface.
- Consumes one sampled bit per `bit_valid` strobe and tracks the frame position itself: data bits, optional parity, 1 or 2 stop bits.
- Delivers a checked word through a valid/ack holding register, with parity-error, stop-error and overrun reporting.

Parameters:
- DATA_WIDTH, 8: data bits per frame; legal range 5..16.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- frame_start  in  1  one-cycle pulse from the start-bit detector; honoured only in IDLE.
- bit_valid  in  1  one-cycle strobe; `sampled_bit` is valid this cycle.
- sampled_bit  in  1  majority-voted line value.
- par_en  in  1  1 = frame carries a parity bit.
- par_odd  in  1  parity type: 0 = even, 1 = odd.
- msb_first  in  1  bit order: 0 = LSB first (UART default), 1 = MSB first.
- data_ack  in  1  consumer accepts `P_DATA`.
- P_DATA  out  DATA_WIDTH  received word.
- data_valid  out  1  `P_DATA`, `par_err` and `stp_err` are valid; held until acked.
- par_err  out  1  parity mismatch for the held word.
- stp_err  out  1  at least one stop bit sampled 0 for the held word.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, `RST`=1 at a clock edge):
  - FSM goes to IDLE.
  - Bit counter, shift register, parity accumulator and stop-error flag clear.
  - All outputs go to 0 on the next edge.
  - `RST` mid-frame discards the partial frame and any held word.
- Configuration latch: `par_en`, `par_odd` and `msb_first` are captured on the accepted `frame_start`. Changes mid-frame have no effect on the current frame.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE -> DATA on `frame_start`. Counter clears, shift register clears, parity accumulator loads `par_odd`.
  - DATA, on each `bit_valid`:
    - Shift `sampled_bit` in. LSB-first: insert at bit `DATA_WIDTH-1` and shift right. MSB-first: insert at bit 0 and shift left.
    - XOR `sampled_bit` into the parity accumulator; counter +1.
    - When the counter reaches `DATA_WIDTH-1` with `bit_valid`, move to PARITY if parity is latched enabled, else STOP.
  - PARITY, on `bit_valid`: `par_calc` = accumulator XOR `sampled_bit`; a nonzero result is a parity error. Go to STOP with the counter cleared.
  - STOP, on each `bit_valid`: OR `~sampled_bit` into the stop-error flag. On the `STOP_BITS`-th stop bit, commit the frame and go to IDLE.
  - Cycles without `bit_valid` hold all state in every state.
  - `frame_start` outside IDLE is ignored.
- Commit (the cycle of the final stop `bit_valid`):
  - Slot free means `data_valid`=0, or `data_ack`=1 in that same cycle.
  - If the slot is free: next edge loads `P_DATA`, `par_err` and `stp_err`, and sets `data_valid`=1. Latency is 1 clock from the final stop strobe.
  - If the slot is not free: the held word is preserved unchanged, the new frame is dropped, and `overrun` pulses high for exactly 1 cycle.
  - The word is delivered even when `stp_err`=1; the error flag accompanies it.
  - `par_err` is 0 whenever parity was disabled.
- Handshake:
  - `data_valid` falls the cycle after `data_ack`=1, unless a commit occurs in the same cycle. In that case it stays 1 with the new word.
  - `data_ack` while `data_valid`=0 is ignored.
  - `P_DATA` holds its value after ack until the next commit.
- Counter width: `$clog2(DATA_WIDTH)+1`. It never exceeds `DATA_WIDTH`; there is no wrap.

Test Plan:
1. DATA_WIDTH=8, LSB-first, no parity, STOP_BITS=1. Send 0xA5 as bits 1,0,1,0,0,1,0,1 then stop=1 -> one cycle after the stop strobe: `P_DATA`=0xA5, `data_valid`=1, `par_err`=0, `stp_err`=0, `busy` low.
2. Same frame with `msb_first`=1. Bits 1,0,1,0,0,1,0,1 -> `P_DATA`=0xA5. Bits 1,1,0,0,0,0,0,0 -> `P_DATA`=0xC0 (LSB-first gives 0x03).
3. Even parity, data 0x07, parity bit 0 -> `par_err`=1. Parity bit 1 -> `par_err`=0. With `par_odd`=1 and parity bit 0 -> `par_err`=0.
4. STOP_BITS=2, data 0x3C, stop bits 1,0 -> `P_DATA`=0x3C, `stp_err`=1, `data_valid`=1.
5. Hold `data_ack`=0 with 0x11 pending, then complete frame 0x22 -> `overrun` high 1 cycle, `P_DATA` stays 0x11. Assert `data_ack` in the exact cycle of the 0x33 final stop strobe -> `data_valid` stays 1, `P_DATA`=0x33, no overrun.
6. Assert `RST` after 4 data bits; `frame_start` pulsed in DATA is ignored -> all outputs 0 after reset. A fresh 0x5A frame then decodes correctly. Also run DATA_WIDTH=5 with frame 0x15 -> `P_DATA`=5'h15.
